// File: rtl/adder_pipe_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_pipe_if : operand/result handshake bundle for adder_pipe
// Revision      : 1.0
// ---------------------------------------------------------------------------
interface adder_pipe_if #(
   parameter int WIDTH = 8
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic             cin;
   logic             sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             cout;
   logic             ovf;

   modport master (
      output in_valid, a, b, cin, sub, out_ready,
      input  in_ready, out_valid, sum, cout, ovf
   );

   modport slave (
      input  in_valid, a, b, cin, sub, out_ready,
      output in_ready, out_valid, sum, cout, ovf
   );
endinterface
`default_nettype wire

// File: rtl/adder_pipe.sv
`default_nettype none
// ---------------------------------------------------------------------------
// adder_pipe : chunked, pipelined adder/subtractor with valid/ready handshake
// Revision   : 1.0
// ---------------------------------------------------------------------------
module adder_pipe #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic        clk,
   input  logic        rst_n,
   adder_pipe_if.slave bus
);
   localparam int CHUNK = WIDTH / STAGES;

   logic                  w_adv;
   logic [STAGES-1:0]     r_valid;
   logic [WIDTH-1:0]      r_a [STAGES];
   logic [WIDTH-1:0]      r_b [STAGES];
   logic [WIDTH-1:0]      r_s [STAGES];
   logic [STAGES-1:0]     r_c;
   logic                  r_ovf;

   logic [STAGES-1:0]     w_vin;
   logic [STAGES-1:0]     w_cin;
   logic [WIDTH-1:0]      w_ain   [STAGES];
   logic [WIDTH-1:0]      w_bin   [STAGES];
   logic [WIDTH-1:0]      w_sin   [STAGES];
   logic [WIDTH-1:0]      w_snext [STAGES];
   logic [CHUNK:0]        w_tot   [STAGES];
   logic                  w_ovf;

   assign w_adv = !r_valid[STAGES-1] || bus.out_ready;

   // Each stage register carries the still-pending upper operand chunks and
   // the already-finished lower sum chunks, so a beat stays aligned end to end.
   always_comb begin
      w_vin[0] = bus.in_valid;
      w_ain[0] = bus.a;
      w_bin[0] = bus.sub ? ~bus.b : bus.b;
      w_cin[0] = bus.sub | bus.cin;
      w_sin[0] = '0;
      for (int k = 1; k < STAGES; k++) begin
         w_vin[k] = r_valid[k-1];
         w_ain[k] = r_a[k-1];
         w_bin[k] = r_b[k-1];
         w_cin[k] = r_c[k-1];
         w_sin[k] = r_s[k-1];
      end
      for (int k = 0; k < STAGES; k++) begin
         w_tot[k] = {1'b0, w_ain[k][k*CHUNK +: CHUNK]}
                  + {1'b0, w_bin[k][k*CHUNK +: CHUNK]}
                  + {{CHUNK{1'b0}}, w_cin[k]};
         w_snext[k] = w_sin[k];
         w_snext[k][k*CHUNK +: CHUNK] = w_tot[k][CHUNK-1:0];
      end
      // carry into the MSB is recovered from the MSB sum bit and its operands
      w_ovf = w_ain[STAGES-1][WIDTH-1] ^ w_bin[STAGES-1][WIDTH-1]
            ^ w_tot[STAGES-1][CHUNK-1] ^ w_tot[STAGES-1][CHUNK];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_valid <= '0;
         r_c     <= '0;
         r_ovf   <= 1'b0;
         for (int k = 0; k < STAGES; k++) begin
            r_a[k] <= '0;
            r_b[k] <= '0;
            r_s[k] <= '0;
         end
      end else if (w_adv) begin
         r_valid <= w_vin;
         for (int k = 0; k < STAGES; k++) begin
            if (w_vin[k]) begin
               r_a[k] <= w_ain[k];
               r_b[k] <= w_bin[k];
               r_s[k] <= w_snext[k];
               r_c[k] <= w_tot[k][CHUNK];
            end
         end
         if (w_vin[STAGES-1]) begin
            r_ovf <= w_ovf;
         end
      end
   end

   assign bus.in_ready  = w_adv;
   assign bus.out_valid = r_valid[STAGES-1];
   assign bus.sum       = r_s[STAGES-1];
   assign bus.cout      = r_c[STAGES-1];
   assign bus.ovf       = r_ovf;

endmodule
`default_nettype wire

// File: doc/adder_pipe.md
Name: adder_pipe

Overview:
- Parametrised, pipelined carry-chain adder/subtractor; next generation of the team's registered 2-bit adder.
- Splits a WIDTH-bit add into STAGES equal chunks. Each chunk is computed in its own pipeline stage, with the carry registered between stages.
- Adds valid/ready handshaking with backpressure, carry-in, subtract mode and a signed-overflow flag.
- Used as the arithmetic datapath element in the 8-bit and wider adder ASIC flows, where chunking relaxes the per-stage timing path.

Parameters:
- WIDTH, 8, operand/result width in bits; must be divisible by STAGES.
- STAGES, 2, number of pipeline stages (chunks); 1 <= STAGES <= WIDTH. STAGES=1 gives a single registered adder.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  block can accept a beat this cycle.
- a  input  WIDTH  operand A, unsigned or two's complement.
- b  input  WIDTH  operand B.
- cin  input  1  carry-in; ignored when sub=1.
- sub  input  1  0: a+b+cin; 1: a-b, computed as a+~b+1.
- out_valid  output  1  result beat valid.
- out_ready  input  1  downstream accepts result.
- sum  output  WIDTH  result, modulo 2^WIDTH.
- cout  output  1  carry out of MSB; in sub mode 1 = no borrow (a>=b unsigned).
- ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB.

Behaviour:
- Reset (rst_n low, async assert, sync release)
  - All stage valid bits, sum, cout and ovf clear to 0.
  - out_valid=0; in_ready=1 after reset.
  - Reset mid-operation discards all in-flight beats; no partial results appear after release.
- Global pipeline enable: adv = !out_valid || out_ready. in_ready = adv (combinational).
- Beat acceptance: a beat is accepted when in_valid && in_ready. Operands, cin and sub are sampled only on acceptance.
- Chunking: C = WIDTH/STAGES bits per chunk.
  - Stage k (k = 0..STAGES-1) adds chunk k of a and b' plus the registered carry from stage k-1. Stage 0 uses cin, or 1 when sub=1.
  - b' = b when sub=0, ~b when sub=1.
- Skew/deskew:
  - Upper operand chunks are delayed k register stages before use.
  - Completed lower sum chunks are delayed (STAGES-1-k) stages.
  - All chunks of one beat therefore emerge together.
- Latency: exactly STAGES cycles from acceptance edge to out_valid=1 with that result, when out_ready held 1.
- Throughput: one beat per cycle when out_ready=1; no bubbles are inserted.
- Stall: when out_valid && !out_ready, every stage register holds.
  - sum/cout/ovf/out_valid stay stable.
  - in_ready=0.
  - No beat is lost or duplicated.
- Bubbles: invalid stages may advance, but only under adv; the pipeline does not compress bubbles while stalled.
- Output flags:
  - cout is the carry out of the final chunk.
  - ovf is derived from the final chunk's MSB carry-in and carry-out.
  - Flags are registered with sum and are valid only when out_valid=1; they hold their previous value otherwise.
- No combinational path from a/b to any output. in_ready depends only on out_valid and out_ready.

Test Plan:
- WIDTH=8, STAGES=2, out_ready=1; accept a=0x01, b=0x01, cin=0, sub=0 at cycle 0 -> out_valid=1 at cycle 2 with sum=0x02, cout=0, ovf=0.
- Cross-chunk carry: a=0x0F, b=0x01 -> sum=0x10. Full carry: a=0xFF, b=0x01 -> sum=0x00, cout=1, ovf=0. Signed overflow: a=0x7F, b=0x01 -> sum=0x80, ovf=1.
- Subtract: a=0x05, b=0x07, sub=1 -> sum=0xFE, cout=0, ovf=0. a=0x80, b=0x01, sub=1 -> sum=0x7F, cout=1, ovf=1. cin=1 with sub=1 gives the same results.
- Back-to-back stream of 4 beats with out_ready held 0 for 3 cycles after first out_valid -> in_ready=0 during stall; outputs stable; all 4 results delivered in order, each exactly once.
- Assert rst_n=0 for 1 cycle mid-stream with 2 beats in flight -> out_valid=0 immediately; no stale result after release; next accepted beat returns after 2 cycles.
- Repeat random a, b, cin and sub against a reference model for (WIDTH, STAGES) = (8,1), (8,4), (16,4), (32,8) -> all sum/cout/ovf match, latency equals STAGES.
